// File: rtl/obi_instr_prefetcher_if.sv
// Instruction-fetch bundle: OBI request/response channel toward memory plus the
// core-side pop handshake of the prefetch buffer.
interface obi_instr_prefetcher_if;
   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_rdata_o;
   logic [31:0] instr_addr_o;

   modport master (
      output obi_req_o, obi_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o,
      input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, instr_ready_i
   );

   modport slave (
      input  obi_req_o, obi_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o,
      output obi_gnt_i, obi_rvalid_i, obi_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/obi_instr_prefetcher.sv
// Sequential OBI instruction prefetcher with a small response FIFO, bounded
// outstanding requests and branch flush that drops stale in-flight responses.
module obi_instr_prefetcher #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BOOT_ADDR       = 32'h0008_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fetch_en_i,
   input  logic                   branch_i,
   input  logic [31:0]            branch_addr_i,
   output logic                   busy_o,
   obi_instr_prefetcher_if.master bus
);
   localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = CW + 1;

   localparam logic [OW-1:0]    MAX_OUT  = OW'(MAX_OUTSTANDING);
   localparam logic [OCC_W-1:0] DEPTH_OC = OCC_W'(FIFO_DEPTH);

   logic [31:0]    fetch_addr_q;
   logic [31:0]    resp_addr_q;
   logic [31:0]    pend_addr_q;
   logic           pend_q;
   logic           stale_q;
   logic [OW-1:0]  outst_q;
   logic [OW-1:0]  outst_d;
   logic [OW-1:0]  discard_q;
   logic [OW-1:0]  discard_d;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;
   logic [PW-1:0]  rd_ptr_q;
   logic [PW-1:0]  wr_ptr_q;
   logic [31:0]    fifo_addr [FIFO_DEPTH];
   logic [31:0]    fifo_data [FIFO_DEPTH];

   logic [OCC_W-1:0] occupancy;
   logic             credit;
   logic             req;
   logic             gnt_fire;
   logic             drop;
   logic             push;
   logic             pop;
   logic             valid;
   logic [31:0]      branch_tgt;
   logic             unused_addr_bits;

   assign branch_tgt       = {branch_addr_i[31:2], 2'b00};
   assign unused_addr_bits = ^branch_addr_i[1:0];

   // Requests already issued reserve a FIFO slot, so a push can never find it full.
   assign occupancy = OCC_W'(outst_q) + OCC_W'(count_q);
   assign credit    = (outst_q < MAX_OUT) && (occupancy < DEPTH_OC);

   // A pending request is never withdrawn, even across a branch.
   assign req      = pend_q | (fetch_en_i & credit & ~branch_i);
   assign gnt_fire = req & bus.obi_gnt_i;
   assign drop     = bus.obi_rvalid_i & (discard_q != '0);
   assign push     = bus.obi_rvalid_i & ~drop & ~branch_i;
   assign valid    = (count_q != '0);
   assign pop      = valid & bus.instr_ready_i & ~branch_i;

   always_comb begin
      outst_d = outst_q;
      if (gnt_fire && !bus.obi_rvalid_i) begin
         outst_d = outst_q + OW'(1);
      end else if (!gnt_fire && bus.obi_rvalid_i) begin
         outst_d = outst_q - OW'(1);
      end
   end

   // On a branch everything still in flight after this cycle belongs to the old stream.
   always_comb begin
      discard_d = discard_q;
      if (gnt_fire && stale_q) begin
         discard_d = discard_d + OW'(1);
      end
      if (drop) begin
         discard_d = discard_d - OW'(1);
      end
      if (branch_i) begin
         discard_d = outst_d;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr_q <= BOOT_ADDR;
         resp_addr_q  <= BOOT_ADDR;
         pend_q       <= 1'b0;
         stale_q      <= 1'b0;
         outst_q      <= '0;
         discard_q    <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         pend_q    <= req & ~bus.obi_gnt_i;
         stale_q   <= req & ~bus.obi_gnt_i & (stale_q | branch_i);
         outst_q   <= outst_d;
         discard_q <= discard_d;

         if (branch_i) begin
            fetch_addr_q <= branch_tgt;
         end else if (gnt_fire && !stale_q) begin
            fetch_addr_q <= fetch_addr_q + 32'd4;
         end

         if (branch_i) begin
            resp_addr_q <= branch_tgt;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
         end else begin
            count_q <= count_d;
            if (push) begin
               resp_addr_q <= resp_addr_q + 32'd4;
               wr_ptr_q    <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
         end
      end
   end

   // Address of an ungranted request, kept so a branch cannot change it mid-handshake.
   always_ff @(posedge clk_i) begin
      if (req && !bus.obi_gnt_i) begin
         pend_addr_q <= bus.obi_addr_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr_q] <= resp_addr_q;
         fifo_data[wr_ptr_q] <= bus.obi_rdata_i;
      end
   end

   assign bus.obi_req_o     = req;
   assign bus.obi_addr_o    = pend_q ? pend_addr_q : fetch_addr_q;
   assign bus.instr_valid_o = valid;
   assign bus.instr_rdata_o = valid ? fifo_data[rd_ptr_q] : 32'd0;
   assign bus.instr_addr_o  = valid ? fifo_addr[rd_ptr_q] : resp_addr_q;
   assign busy_o            = req | (outst_q != '0);
endmodule

// File: tb/tb_obi_instr_prefetcher.sv
// Directed bench for obi_instr_prefetcher with a behavioural instruction memory
// (combinational grant, response after a selectable 1- or 2-cycle latency).
module tb_obi_instr_prefetcher;
   localparam logic [31:0] BOOT = 32'h0008_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        branch;
   logic [31:0] branch_addr;
   logic        busy;
   logic        gnt_en;
   logic        ready;
   int          lat;
   logic        s1_v = 1'b0;
   logic        s2_v = 1'b0;
   logic [31:0] s1_a = 32'd0;
   logic [31:0] s2_a = 32'd0;
   logic [31:0] exp_addr;
   int          total = 0;
   int          bad = 0;

   obi_instr_prefetcher_if bus ();

   obi_instr_prefetcher #(
      .FIFO_DEPTH(4),
      .MAX_OUTSTANDING(2),
      .BOOT_ADDR(BOOT)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .fetch_en_i(fetch_en),
      .branch_i(branch),
      .branch_addr_i(branch_addr),
      .busy_o(busy),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a;
   endfunction

   assign bus.obi_gnt_i     = gnt_en;
   assign bus.instr_ready_i = ready;
   assign bus.obi_rvalid_i  = (lat == 2) ? s2_v : s1_v;
   assign bus.obi_rdata_i   = mem_word((lat == 2) ? s2_a : s1_a);

   always @(posedge clk) begin
      s1_v <= bus.obi_req_o & bus.obi_gnt_i;
      s1_a <= bus.obi_addr_o;
      s2_v <= s1_v;
      s2_a <= s1_a;
   end

   always @(posedge clk) begin
      if (rst === 1'b0 && dut.push === 1'b1 && dut.count_q == 3'd4) begin
         bad++;
         $display("FAIL fifo_overflow push with count=%0d required<4", dut.count_q);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; fetch_en = 1'b0; branch = 1'b0; branch_addr = 32'd0;
      gnt_en = 1'b1; ready = 1'b0; lat = 1;
      repeat (3) tick();
      #2;
      total++; if (bus.obi_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.obi_req_o); end
      total++; if (bus.obi_addr_o !== BOOT) begin bad++; $display("FAIL reset_obi_addr got=%h want=%h", bus.obi_addr_o, BOOT); end
      total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.instr_valid_o); end
      total++; if (bus.instr_rdata_o !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.instr_rdata_o); end
      total++; if (bus.instr_addr_o !== BOOT) begin bad++; $display("FAIL reset_instr_addr got=%h want=%h", bus.instr_addr_o, BOOT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
   endtask

   task automatic test_boot_stream();
      rst = 1'b0; fetch_en = 1'b1;
      #1;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== BOOT) begin bad++; $display("FAIL boot_req got=%b/%h want=1/%h", bus.obi_req_o, bus.obi_addr_o, BOOT); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL boot_busy got=%b want=1", busy); end
      tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL boot_c1_valid got=%b want=0", bus.instr_valid_o); end
      total++; if (bus.obi_addr_o !== 32'h0008_0004) begin bad++; $display("FAIL boot_c1_addr got=%h want=00080004", bus.obi_addr_o); end
      tick(); ready = 1'b1; #2;
      exp_addr = BOOT;
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== BOOT || bus.instr_rdata_o !== 32'hFFF7_FFFF) begin
         bad++; $display("FAIL boot_first got=%b/%h/%h want=1/%h/fff7ffff", bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o, BOOT);
      end
      for (int i = 0; i < 8; i++) begin
         tick(); exp_addr += 32'd4; #2;
         total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== exp_addr || bus.instr_rdata_o !== mem_word(exp_addr)) begin
            bad++; $display("FAIL stream_%0d got=%b/%h/%h want=1/%h/%h", i, bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o, exp_addr, mem_word(exp_addr));
         end
         total++; if (dut.outst_q > 2'd2) begin bad++; $display("FAIL stream_outst got=%0d want<=2", dut.outst_q); end
      end
   endtask

   task automatic test_backpressure();
      tick(); exp_addr += 32'd4; ready = 1'b0;
      repeat (6) tick();
      #2;
      total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", dut.count_q); end
      total++; if (bus.obi_req_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_req_busy got=%b/%b want=0/0", bus.obi_req_o, busy); end
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== exp_addr) begin bad++; $display("FAIL bp_head got=%b/%h want=1/%h", bus.instr_valid_o, bus.instr_addr_o, exp_addr); end
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(); exp_addr += 32'd4; #2;
         total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== exp_addr || bus.instr_rdata_o !== mem_word(exp_addr)) begin
            bad++; $display("FAIL bp_drain_%0d got=%b/%h/%h want=1/%h/%h", i, bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o, exp_addr, mem_word(exp_addr));
         end
      end
   endtask

   task automatic drain_and_restart(input int new_lat);
      int n;
      fetch_en = 1'b0; ready = 1'b1; gnt_en = 1'b1;
      n = 0;
      #2;
      while ((busy !== 1'b0 || bus.instr_valid_o !== 1'b0) && n < 20) begin
         tick(); #2; n++;
      end
      total++; if (busy !== 1'b0 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL drain_timeout busy=%b valid=%b want=0/0", busy, bus.instr_valid_o); end
      branch = 1'b1; branch_addr = 32'h0000_0040;
      tick();
      branch = 1'b0; lat = new_lat;
   endtask

   task automatic test_branch_outstanding();
      drain_and_restart(2);
      fetch_en = 1'b1; #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h40) begin bad++; $display("FAIL bro_k0 got=%b/%h want=1/00000040", bus.obi_req_o, bus.obi_addr_o); end
      tick(); #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h44) begin bad++; $display("FAIL bro_k1 got=%b/%h want=1/00000044", bus.obi_req_o, bus.obi_addr_o); end
      tick(); branch = 1'b1; branch_addr = 32'h0000_0100; #2;
      total++; if (bus.obi_req_o !== 1'b0) begin bad++; $display("FAIL bro_branch_req got=%b want=0", bus.obi_req_o); end
      tick(); branch = 1'b0; #2;
      total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL bro_flush got=%b want=0", bus.instr_valid_o); end
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h100) begin bad++; $display("FAIL bro_target_req got=%b/%h want=1/00000100", bus.obi_req_o, bus.obi_addr_o); end
      for (int i = 0; i < 2; i++) begin
         tick(); #2;
         total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL bro_drop_%0d got=%b/%h want=0", i, bus.instr_valid_o, bus.instr_addr_o); end
      end
      tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== 32'h100 || bus.instr_rdata_o !== 32'hFFFF_FEFF) begin
         bad++; $display("FAIL bro_first got=%b/%h/%h want=1/00000100/fffffeff", bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o);
      end
      tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== 32'h104) begin bad++; $display("FAIL bro_second got=%b/%h want=1/00000104", bus.instr_valid_o, bus.instr_addr_o); end
   endtask

   task automatic test_branch_ungranted();
      drain_and_restart(1);
      fetch_en = 1'b1; gnt_en = 1'b0; #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h40) begin bad++; $display("FAIL bru_j0 got=%b/%h want=1/00000040", bus.obi_req_o, bus.obi_addr_o); end
      tick(); branch = 1'b1; branch_addr = 32'h0000_0100; #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h40) begin bad++; $display("FAIL bru_branch got=%b/%h want=1/00000040", bus.obi_req_o, bus.obi_addr_o); end
      tick(); branch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) gnt_en = 1'b1;
         #2;
         total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h40) begin bad++; $display("FAIL bru_hold_%0d got=%b/%h want=1/00000040", i, bus.obi_req_o, bus.obi_addr_o); end
         tick();
      end
      #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h100) begin bad++; $display("FAIL bru_next got=%b/%h want=1/00000100", bus.obi_req_o, bus.obi_addr_o); end
      tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL bru_drop got=%b/%h want=0", bus.instr_valid_o, bus.instr_addr_o); end
      tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== 32'h100 || bus.instr_rdata_o !== 32'hFFFF_FEFF) begin
         bad++; $display("FAIL bru_first got=%b/%h/%h want=1/00000100/fffffeff", bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o);
      end
   endtask

   task automatic test_align_wrap();
      tick(); branch = 1'b1; branch_addr = 32'h0000_0103; #2;
      total++; if (bus.obi_req_o !== 1'b0) begin bad++; $display("FAIL align_branch_req got=%b want=0", bus.obi_req_o); end
      tick(); branch = 1'b0; #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h100) begin bad++; $display("FAIL align_req got=%b/%h want=1/00000100", bus.obi_req_o, bus.obi_addr_o); end
      tick(); tick(); #2;
      total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== 32'h100 || bus.instr_rdata_o !== 32'hFFFF_FEFF) begin
         bad++; $display("FAIL align_instr got=%b/%h/%h want=1/00000100/fffffeff", bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o);
      end
      tick(); branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
      tick(); branch = 1'b0; #2;
      total++; if (bus.obi_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req0 got=%h want=fffffffc", bus.obi_addr_o); end
      tick(); #2;
      total++; if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_req1 got=%b/%h want=1/00000000", bus.obi_req_o, bus.obi_addr_o); end
      tick(); #2;
      total++; if (bus.instr_addr_o !== 32'hFFFF_FFFC || bus.instr_rdata_o !== 32'h0000_0003) begin bad++; $display("FAIL wrap_instr0 got=%h/%h want=fffffffc/00000003", bus.instr_addr_o, bus.instr_rdata_o); end
      tick(); #2;
      total++; if (bus.instr_addr_o !== 32'h0 || bus.instr_rdata_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_instr1 got=%h/%h want=00000000/ffffffff", bus.instr_addr_o, bus.instr_rdata_o); end
   endtask

   task automatic test_reset_mid();
      tick(); fetch_en = 1'b0; rst = 1'b1;
      tick(); tick(); #2;
      total++; if (bus.obi_req_o !== 1'b0 || bus.obi_addr_o !== BOOT) begin bad++; $display("FAIL rmid_req got=%b/%h want=0/%h", bus.obi_req_o, bus.obi_addr_o, BOOT); end
      total++; if (bus.instr_valid_o !== 1'b0 || bus.instr_addr_o !== BOOT || bus.instr_rdata_o !== 32'd0) begin
         bad++; $display("FAIL rmid_instr got=%b/%h/%h want=0/%h/0", bus.instr_valid_o, bus.instr_addr_o, bus.instr_rdata_o, BOOT);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_boot_stream();
      test_backpressure();
      test_branch_outstanding();
      test_branch_ungranted();
      test_align_wrap();
      test_reset_mid();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/obi_instr_prefetcher.md
# obi_instr_prefetcher

OBI initiator that fetches instructions for the core from the memory subsystem's instruction port (Boot ROM at 0x0008_0000, IRAM at 0x0000_0000). It issues sequential word fetches and keeps up to MAX_OUTSTANDING requests in flight. Responses are buffered in a small FIFO that the core pops with a valid/ready handshake. On a branch it flushes the FIFO, drops responses that are still in flight, and restarts at the target address.

## Interface
- FIFO_DEPTH, 4: prefetch buffer entries (power of two, ≥ MAX_OUTSTANDING)
- MAX_OUTSTANDING, 2: maximum granted-but-not-responded requests
- BOOT_ADDR, 32'h0008_0000: fetch address after reset

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- fetch_en_i  in  1  allow new requests
- branch_i  in  1  redirect pulse (one cycle)
- branch_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0)
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  core accepts head
- instr_rdata_o  out  32  head instruction word
- instr_addr_o  out  32  head word address
- busy_o  out  1  obi_req_o | (outstanding ≠ 0)
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  OBI word address
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI response data

## Operation
- **State**
  - fetch_addr_q: next request address; reset BOOT_ADDR.
  - resp_addr_q: address of the next accepted response; reset BOOT_ADDR.
  - pend_q: request asserted last cycle and not yet granted.
  - stale_q: the pending request predates a branch.
  - outst_q: outstanding count, width clog2(MAX_OUTSTANDING+1).
  - discard_q: count of in-flight responses to drop.
  - FIFO: {addr, data} entries with count_q.
- **Credit**
  - credit = (outst_q < MAX_OUTSTANDING) && (outst_q + count_q < FIFO_DEPTH).
  - Discarded in-flight requests still consume credit.
- **Request**
  - obi_req_o = pend_q | (fetch_en_i & credit & ~branch_i).
  - obi_addr_o = fetch_addr_q.
- **OBI stability rule**
  - Once obi_req_o is asserted, req and addr stay stable until gnt.
  - This holds regardless of fetch_en_i, branch_i or credit.
- **Grant** (req & gnt)
  - outst_q +1.
  - If not stale: fetch_addr_q += 4, wrapping at 2^32 (0xFFFF_FFFC → 0x0000_0000).
  - If stale_q: discard_q +1, stale_q cleared, fetch_addr_q keeps the branch target.
- **Response** (rvalid)
  - outst_q −1; a simultaneous grant leaves outst_q unchanged.
  - If discard_q ≠ 0: data dropped, discard_q −1.
  - Otherwise push {resp_addr_q, obi_rdata_i} and add 4 to resp_addr_q.
- **Pop**: instr_valid_o & instr_ready_i removes the head. Push and pop in the same cycle leave count_q unchanged.
- **Branch** (branch_i=1) overrides push and pop in that cycle:
  - FIFO cleared (count_q=0).
  - fetch_addr_q and resp_addr_q ← {branch_addr_i[31:2], 2'b00}.
  - discard_q ← outst_q after this cycle's grant/response updates, minus any response dropped this cycle.
  - If a request is asserted and not granted this cycle: stale_q←1, and its address is held until it is granted.
  - If a granted request is in the same cycle as branch_i, it counts as discarded. fetch_addr_q still takes the target.
- **FIFO full**: cannot occur under the credit rule. A push when full is a design error, covered by an assertion in the bench.
- **fetch_en_i=0**
  - No new requests; a pending request still completes.
  - Responses in flight still land in the FIFO.
- **Reset mid-operation**: all state returns to reset values. Responses arriving after reset are outside the contract.

## Timing
- Reset values:
  - obi_req_o=0, obi_addr_o=BOOT_ADDR.
  - instr_valid_o=0, instr_rdata_o=0, instr_addr_o=BOOT_ADDR, busy_o=0.
  - All counters and flags 0.
- The memory grants combinationally and responds one cycle after grant.
- First cycle after reset with fetch_en_i=1:
  - Cycle 0: req to BOOT_ADDR, gnt.
  - Cycle 1: rvalid.
  - Cycle 2: instr_valid_o.
- FIFO output is registered: minimum 1 cycle from rvalid to instr_valid_o, with no bypass.
- Sustained throughput is 1 word/cycle with MAX_OUTSTANDING ≥ 2 and a zero-wait memory.
- Branch at cycle N:
  - No new request in N.
  - Target request in N+1 if no stale pending request.
  - Target instruction visible at N+3 at the earliest.

## Test plan
- **Reset/boot**: hold rst_i 3 cycles, then fetch_en_i=1, gnt=1 → outputs at reset values during reset; first obi_addr_o=0x0008_0000; instr_addr_o=0x0008_0000 two cycles later with the ROM word.
- **Streaming**: gnt=1, rvalid next cycle, ready=1 → instr_addr_o 0x80000, 0x80004, 0x80008… one per cycle, no gaps after startup; outst_q ≤ 2.
- **Backpressure**: instr_ready_i=0 → count reaches 4, obi_req_o deasserts, no overflow; ready=1 → all words delivered in order, none lost.
- **Branch with 2 outstanding**: branch to 0x0000_0100 → two old responses dropped; first delivered is instr_addr_o=0x100 with its IRAM data; FIFO empty in the cycle after the branch.
- **Branch with ungranted request**: gnt=0 for 3 cycles after the branch → obi_addr_o stays at the old address until granted; that response is dropped; next request is 0x100.
- **Alignment and wrap**: branch to 0x0000_0103 → fetch 0x100; branch to 0xFFFF_FFFC → following request 0x0000_0000.
